// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the shared UART transmitter.
// A grant is held for a whole message, or until the owner stalls too long.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 250000,
  parameter int IDW     = 3
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_busy,
  output logic              tx_stb,
  output logic [7:0]        tx_data,
  output logic              active,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_evt
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_stb_q, tx_stb_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            active_q, active_d;
  logic            evt_q, evt_d;

  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic            can_send;
  logic            accept;

  // Mux out the current owner's request signals.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // First valid requester, scanning circularly after the last owner.
  always_comb begin
    int t;
    t          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      t = int'(last_q) + k;
      if (t >= NREQ) t = t - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found && i == t && req_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = IDW'(i);
        end
      end
    end
  end

  // A strobe in flight counts as busy so the UART is never written twice.
  assign can_send = !tx_stb_q && !tx_busy;
  assign accept   = (state_q == LOCKED) && own_valid && can_send;

  // Only the owner sees ready, and only when the UART can take a byte.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == LOCKED) && can_send
                     && (owner_q == IDW'(i));
    end
  end

  // Grant, transfer and timeout sequencing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tx_stb_d  = 1'b0;
    tx_data_d = tx_data_q;
    active_d  = active_q;
    evt_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = LOCKED;
          owner_d  = pick_idx;
          active_d = 1'b1;
          cnt_d    = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          tx_stb_d  = 1'b1;
          tx_data_d = own_data;
          cnt_d     = '0;
          if (own_last) begin
            state_d  = IDLE;
            active_d = 1'b0;
            last_d   = owner_q;
          end
        end else if (TIMEOUT > 0 && !own_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            active_d = 1'b0;
            evt_d    = 1'b1;
            last_d   = owner_q;
            cnt_d    = '0;
          end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= LAST_INIT;
      cnt_q     <= '0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= 8'h00;
      active_q  <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
      active_q  <= active_d;
      evt_q     <= evt_d;
    end
  end

  assign tx_stb      = tx_stb_q;
  assign tx_data     = tx_data_q;
  assign active      = active_q;
  assign grant_id    = owner_q;
  assign timeout_evt = evt_q;

endmodule
